// File: rtl/sseg_dev.sv
// Serial driver for an eight-digit seven-segment display behind a 74HC164 shift chain.
// Define SSEG_FLASH_EN to blank the digits selected by LES while flash is high.
module sseg_dev (
    input  logic        clk,
    input  logic        rstn,
    input  logic        Start,
    input  logic        flash,
    input  logic [31:0] Hexs,
    input  logic [7:0]  point,
    input  logic [7:0]  LES,
    output logic        seg_clk,
    output logic        seg_clrn,
    output logic        seg_sout,
    output logic        SEG_PEN
);

    logic [2:0]  sync;
    logic        start_evt;
    logic        busy;
    logic [6:0]  cnt;
    logic [63:0] frame;
    logic [63:0] snap;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] hex);
        logic [7:0] pat;
        case (hex)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat[6:0];
    endfunction

`ifdef SSEG_FLASH_EN
    always_comb begin
        snap = '0;
        for (int i = 0; i < 8; i++) begin
            if (LES[i] && flash)
                snap[8*i +: 8] = 8'hFF;
            else
                snap[8*i +: 8] = {~point[i], seg7(Hexs[4*i +: 4])};
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^{LES, flash};

    always_comb begin
        snap = '0;
        for (int i = 0; i < 8; i++)
            snap[8*i +: 8] = {~point[i], seg7(Hexs[4*i +: 4])};
    end
`endif

    // sync[1] is the synchronized Start, sync[2] its previous value.
    assign start_evt = sync[1] & ~sync[2];

    // cnt[0]=0 is cycle A of a bit (data presented), cnt[0]=1 is cycle B (clock high).
    // frame holds the bits still to send, MSB next; seg_sout already carries the current bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync     <= '0;
            busy     <= 1'b0;
            cnt      <= '0;
            frame    <= '0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            seg_clrn <= 1'b0;
            SEG_PEN  <= 1'b0;
        end else begin
            sync     <= {sync[1:0], Start};
            seg_clrn <= 1'b1;
            if (!busy) begin
                seg_clk <= 1'b0;
                if (start_evt) begin
                    busy     <= 1'b1;
                    SEG_PEN  <= 1'b0;
                    cnt      <= '0;
                    seg_sout <= snap[63];
                    frame    <= {snap[62:0], 1'b0};
                end
            end else if (!cnt[0]) begin
                seg_clk <= 1'b1;
                cnt     <= cnt + 7'd1;
            end else if (cnt == 7'd127) begin
                seg_clk <= 1'b0;
                SEG_PEN <= 1'b1;
                busy    <= 1'b0;
                cnt     <= '0;
            end else begin
                seg_clk  <= 1'b0;
                seg_sout <= frame[63];
                frame    <= {frame[62:0], 1'b0};
                cnt      <= cnt + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_dev.sv
// Self-checking bench for sseg_dev: directed cases plus randomized frames against a table-driven model.
module tb_sseg_dev;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        Start = 1'b0;
    logic        flash = 1'b0;
    logic [31:0] Hexs = '0;
    logic [7:0]  point = '0;
    logic [7:0]  LES = '0;
    logic        seg_clk, seg_clrn, seg_sout, SEG_PEN;

    int compared = 0;
    int mismatched = 0;
    logic bits[$];

    sseg_dev dut (
        .clk(clk), .rstn(rstn), .Start(Start), .flash(flash), .Hexs(Hexs),
        .point(point), .LES(LES), .seg_clk(seg_clk), .seg_clrn(seg_clrn),
        .seg_sout(seg_sout), .SEG_PEN(SEG_PEN)
    );

    always #5 clk = ~clk;

    // The external 74HC164 samples data on the rising shift clock.
    always @(posedge seg_clk) bits.push_back(seg_sout);

    function automatic logic [63:0] model_frame(input logic [31:0] h, input logic [7:0] p,
                                                input logic [7:0] l, input logic f);
        logic [7:0] tbl [16];
        logic [63:0] fr;
        logic [7:0] b;
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        fr = '0;
        for (int i = 0; i < 8; i++) begin
            b = tbl[h[4*i +: 4]];
            if (p[i]) b[7] = 1'b0;
`ifdef SSEG_FLASH_EN
            if (l[i] && f) b = 8'hFF;
`endif
            fr[8*i +: 8] = b;
        end
        return fr;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] got_frame();
        logic [63:0] g;
        g = 'x;
        for (int i = 0; i < 64 && i < bits.size(); i++) g[63-i] = bits[i];
        return g;
    endfunction

    // disturb: 0 none, 1 change inputs mid-transfer, 2 second Start pulse near bit 20
    task automatic do_transfer(input string tag, input logic [31:0] h, input logic [7:0] p,
                               input logic [7:0] l, input logic f, input int disturb);
        logic [63:0] exp;
        int n;
        exp = model_frame(h, p, l, f);
        Hexs = h; point = p; LES = l; flash = f;
        bits.delete();
        @(negedge clk); Start = 1'b1;
        repeat (3) @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (bits.size() < 64 && n < 400) begin
            @(negedge clk);
            n++;
            if (disturb == 1 && bits.size() == 10) begin
                Hexs = ~h; point = ~p; LES = ~l; flash = ~f;
            end
            if (disturb == 2 && bits.size() == 20) Start = 1'b1;
            if (disturb == 2 && bits.size() == 23) Start = 1'b0;
        end
        check({tag, "_last_bit_pen"}, {62'd0, SEG_PEN, seg_clk}, 64'd1);
        @(negedge clk);
        check({tag, "_done_pen"}, {62'd0, SEG_PEN, seg_clk}, 64'd2);
        repeat (8) @(negedge clk);
        check({tag, "_pulses"}, 64'(bits.size()), 64'd64);
        check({tag, "_frame"}, got_frame(), exp);
        check({tag, "_idle_clk"}, {63'd0, seg_clk}, 64'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", {60'd0, seg_clk, seg_sout, SEG_PEN, seg_clrn}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("clrn_after_rst", {63'd0, seg_clrn}, 64'd1);
        check("no_shift_idle", 64'(bits.size()), 64'd0);

        do_transfer("basic", 32'h0123_4567, 8'h00, 8'h00, 1'b0, 0);
        check("basic_bytes", got_frame(), 64'hC0F9A4B0_999282F8);
        do_transfer("points", 32'hFFFF_FFFF, 8'h41, 8'h00, 1'b0, 0);
        check("points_bytes", got_frame(), 64'h8E0E8E8E_8E8E8E0E);
        do_transfer("flash_on", 32'h0, 8'h00, 8'h01, 1'b1, 0);
`ifdef SSEG_FLASH_EN
        check("flash_on_bytes", got_frame(), 64'hC0C0C0C0_C0C0C0FF);
`else
        check("flash_on_bytes", got_frame(), 64'hC0C0C0C0_C0C0C0C0);
`endif
        do_transfer("flash_off", 32'h0, 8'h00, 8'h01, 1'b0, 0);
        check("flash_off_bytes", got_frame(), 64'hC0C0C0C0_C0C0C0C0);
        do_transfer("second_start", 32'h89AB_CDEF, 8'h80, 8'h00, 1'b0, 2);
        do_transfer("mid_change", 32'hDEAD_BEEF, 8'h5A, 8'hF0, 1'b1, 1);

        for (int k = 0; k < 4; k++)
            do_transfer($sformatf("rand%0d", k), $urandom, 8'($urandom), 8'($urandom),
                        1'($urandom), int'($urandom_range(0, 2)));

        // reset in the middle of a transfer
        Hexs = 32'h1357_9BDF;
        bits.delete();
        @(negedge clk); Start = 1'b1;
        repeat (3) @(negedge clk);
        Start = 1'b0;
        for (int n = 0; n < 400 && bits.size() < 20; n++) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_outputs", {61'd0, seg_clk, SEG_PEN, seg_clrn}, 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_shift", 64'(bits.size()), 64'd20);
        check("abort_clrn", {63'd0, seg_clrn}, 64'd1);
        do_transfer("after_abort", 32'h2468_ACE0, 8'h0F, 8'h00, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
